// File: rtl/gfmux_pkg.sv
// gfmux_pkg: shared types for the glitch-free clock mux.
// Holds the select FSM state enum and the select-width helper.
package gfmux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIS,
    EN,
    ACK
  } gfmux_state_e;

  // One spare code beyond the channel count so that an
  // out-of-range request can be expressed and rejected.
  function automatic int sel_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gfmux_chan_gate.sv
// gfmux_chan_gate: per-channel enable sync, negedge clock gate and
// clk1 feedback. Ports: clk1, rstn, clk_src, en_req, force_clr, gclk, fb.
module gfmux_chan_gate #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk1,
  input  logic rstn,
  input  logic clk_src,
  input  logic en_req,
  input  logic force_clr,
  output logic gclk,
  output logic fb
);

  logic                   rst_c;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   en_g;
  logic [1:0]             fb_q;

  // force_clr lets clk1 kill the gate when clk_src is dead.
  assign rst_c = rstn & ~force_clr;

  always_ff @(posedge clk_src or negedge rst_c) begin
    if (!rst_c) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], en_req};
  end

  // Changing on the falling edge keeps the AND gate glitch-free.
  always_ff @(negedge clk_src or negedge rst_c) begin
    if (!rst_c) en_g <= 1'b0;
    else        en_g <= sync_q[SYNC_STAGES-1];
  end

  assign gclk = clk_src & en_g;

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) fb_q <= '0;
    else       fb_q <= {fb_q[0], en_g};
  end

  assign fb = fb_q[1];

endmodule

// File: rtl/glitch_free_mux_n.sv
// glitch_free_mux_n: N-input glitch-free clock mux with clk1 select FSM.
// Ports: clk1, rstn, clk_in, sel_req, sel -> sel_ack, sel_err, cur_sel,
// busy, clk_out. Define GFMUX_TIMEOUT_EN for dead-clock timeouts.
module glitch_free_mux_n
  import gfmux_pkg::*;
#(
  parameter int N_CLK       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEFAULT_SEL = 0,
  parameter int TIMEOUT     = 1023
) (
  input  logic                    clk1,
  input  logic                    rstn,
  input  logic [N_CLK-1:0]        clk_in,
  input  logic                    sel_req,
  input  logic [sel_w(N_CLK)-1:0] sel,
  output logic                    sel_ack,
  output logic                    sel_err,
  output logic [sel_w(N_CLK)-1:0] cur_sel,
  output logic                    busy,
  output logic                    clk_out
);

  localparam int SW = sel_w(N_CLK);

  typedef logic [SW-1:0]    sel_t;
  typedef logic [N_CLK-1:0] vec_t;

  localparam logic [SW:0] NCLK_W = N_CLK[SW:0];

  function automatic vec_t onehot(input sel_t s);
    vec_t v;
    v = '0;
    for (int i = 0; i < N_CLK; i++)
      v[i] = (s == sel_t'(i));
    return v;
  endfunction

  gfmux_state_e state, state_n;
  sel_t         cur_q, cur_n;
  sel_t         tgt_q, tgt_n;
  vec_t         en_q, en_n;
  vec_t         fclr_q, fclr_n;
  vec_t         fb, gclk;
  logic         err_q, err_n;
  logic         init_q, init_n;
  logic         fb_old, fb_new;
  logic         in_range;
  logic         tmo;

  assign fb_old   = |(fb & onehot(cur_q));
  assign fb_new   = |(fb & onehot(tgt_q));
  assign in_range = {1'b0, sel} < NCLK_W;

`ifdef GFMUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  assign tmo = (cnt_q == CW'(TIMEOUT));

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn)
      cnt_q <= '0;
    else if (state_n != state ||
             !(state inside {DIS, EN}))
      cnt_q <= '0;
    else if (!tmo)
      cnt_q <= cnt_q + CW'(1);
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      state  <= EN;
      cur_q  <= sel_t'(DEFAULT_SEL);
      tgt_q  <= sel_t'(DEFAULT_SEL);
      en_q   <= '0;
      fclr_q <= '0;
      err_q  <= 1'b0;
      init_q <= 1'b1;
    end else begin
      state  <= state_n;
      cur_q  <= cur_n;
      tgt_q  <= tgt_n;
      en_q   <= en_n;
      fclr_q <= fclr_n;
      err_q  <= err_n;
      init_q <= init_n;
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur_q;
    tgt_n   = tgt_q;
    en_n    = en_q;
    fclr_n  = fclr_q;
    err_n   = err_q;
    init_n  = init_q;
    unique case (state)
      IDLE: begin
        if (sel_req) begin
          unique case (1'b1)
            !in_range: begin
              state_n = ACK;
              err_n   = 1'b1;
            end
            (sel == cur_q): begin
              state_n = ACK;
              err_n   = 1'b0;
            end
            default: begin
              state_n = DIS;
              tgt_n   = sel;
              en_n    = '0;
              err_n   = 1'b0;
            end
          endcase
        end
      end
      DIS: begin
        if (!fb_old) begin
          state_n = EN;
          en_n    = onehot(tgt_q);
        end else if (tmo) begin
          // Old clock is dead: clear its gate from here.
          state_n = EN;
          en_n    = onehot(tgt_q);
          fclr_n  = onehot(cur_q);
        end
      end
      EN: begin
        en_n = onehot(tgt_q);
        if (fb_new) begin
          if (init_q) begin
            state_n = IDLE;
            init_n  = 1'b0;
          end else begin
            state_n = ACK;
            cur_n   = tgt_q;
          end
        end else if (tmo && !init_q) begin
          // New clock is dead: fall back to the old one.
          state_n = ACK;
          err_n   = 1'b1;
          en_n    = onehot(cur_q);
          tgt_n   = cur_q;
        end
      end
      ACK: begin
        state_n = IDLE;
        fclr_n  = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  for (genvar i = 0; i < N_CLK; i++) begin : g_ch
    gfmux_chan_gate #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_gate (
      .clk1     (clk1),
      .rstn     (rstn),
      .clk_src  (clk_in[i]),
      .en_req   (en_q[i]),
      .force_clr(fclr_q[i]),
      .gclk     (gclk[i]),
      .fb       (fb[i])
    );
  end

  assign clk_out = |gclk;
  assign sel_ack = (state == ACK);
  assign sel_err = (state == ACK) & err_q;
  assign busy    = (state != IDLE);
  assign cur_sel = cur_q;

endmodule

// File: tb/tb_glitch_free_mux_n.sv
// tb_glitch_free_mux_n: randomized scoreboard bench for the clock mux.
// Build with GFMUX_TIMEOUT_EN to also exercise the dead-clock path.
module tb_glitch_free_mux_n;

  localparam int N  = 4;
  localparam int SW = $clog2(N + 1);
`ifdef GFMUX_TIMEOUT_EN
  localparam int TMO = 15;
`else
  localparam int TMO = 1023;
`endif

  typedef struct {
    logic          err;
    logic [SW-1:0] cur;
  } exp_t;

  logic          clk1 = 1'b0;
  logic          rstn = 1'b0;
  logic          sel_req = 1'b0;
  logic [SW-1:0] sel = '0;
  logic          c0 = 1'b0, c1 = 1'b0;
  logic          c2 = 1'b0, c3 = 1'b0;
  logic          stop3 = 1'b0;
  logic [N-1:0]  clk_in;
  logic          sel_ack, sel_err, busy, clk_out;
  logic [SW-1:0] cur_sel;
  logic [1:0]    fsel = '0;
  logic          fclk;

  int     checks = 0;
  int     errors = 0;
  int     model_cur = 0;
  exp_t   q[$];
  exp_t   mon_e;
  longint t_last = 0;
  longint min_w = 1000;

  assign clk_in = {c3, c2, c1, c0};
  assign fclk   = clk_in[fsel];

  always #10 clk1 = ~clk1;
  always #5  c0 = ~c0;
  always #12 c1 = ~c1;
  always #15 c2 = ~c2;
  always #8  c3 = stop3 ? 1'b0 : ~c3;

  glitch_free_mux_n #(
    .N_CLK      (N),
    .SYNC_STAGES(2),
    .DEFAULT_SEL(0),
    .TIMEOUT    (TMO)
  ) dut (
    .clk1   (clk1),
    .rstn   (rstn),
    .clk_in (clk_in),
    .sel_req(sel_req),
    .sel    (sel),
    .sel_ack(sel_ack),
    .sel_err(sel_err),
    .cur_sel(cur_sel),
    .busy   (busy),
    .clk_out(clk_out)
  );

  task automatic chk(input string nm, input longint got,
                     input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t",
               nm, got, want, $time);
    end
  endtask

  // Scoreboard monitor: every ack must match a queued request.
  always @(negedge clk1) begin
    if (rstn && sel_ack) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack got ack err=%0b want none",
                 sel_err);
      end else begin
        mon_e = q.pop_front();
        chk("ack_err", longint'(sel_err), longint'(mon_e.err));
        chk("ack_cur", longint'(cur_sel), longint'(mon_e.cur));
      end
    end
  end

  // Shortest clk_out phase outside reset.
  always @(clk_out) begin
    if (rstn && t_last != 0 && ($time - t_last) < min_w)
      min_w = $time - t_last;
    t_last = $time;
  end

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk1);
      n++;
    end
    chk({nm, "_idle"}, longint'(busy), 0);
  endtask

  task automatic check_follow(input int k);
    fsel = k[1:0];
    #1;
    repeat (3) begin
      @(posedge fclk);
      #1;
      chk("follow_hi", longint'(clk_out), 1);
      @(negedge fclk);
      #1;
      chk("follow_lo", longint'(clk_out), 0);
    end
  endtask

  task automatic do_req(input int s, input bit poke,
                        input bit dead);
    exp_t e;
    bit   imm;
    @(negedge clk1);
    sel     = s[SW-1:0];
    sel_req = 1'b1;
    imm     = !dead && (s >= N || s == model_cur);
    e.err   = dead || (s >= N);
    if (!dead && s < N) model_cur = s;
    e.cur   = model_cur[SW-1:0];
    q.push_back(e);
    @(negedge clk1);
    sel_req = 1'b0;
    chk("busy_rise", longint'(busy), 1);
    if (imm) chk("imm_ack", longint'(sel_ack), 1);
    if (poke && !imm) begin
      sel     = SW'((s + 1) % N);
      sel_req = 1'b1;
      @(negedge clk1);
      sel_req = 1'b0;
    end
    wait_idle("req", 400);
    chk("cur_sel", longint'(cur_sel), longint'(model_cur));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int s;
    rstn = 1'b0;
    repeat (3) @(negedge clk1);
    chk("rst_busy", longint'(busy), 1);
    chk("rst_ack", longint'(sel_ack), 0);
    chk("rst_err", longint'(sel_err), 0);
    chk("rst_cur", longint'(cur_sel), 0);
    @(posedge c0);
    #1;
    chk("rst_clkout", longint'(clk_out), 0);
    rstn = 1'b1;
    @(negedge clk1);
    wait_idle("boot", 200);
    check_follow(0);

    do_req(2, 0, 0);
    check_follow(2);
    do_req(1, 0, 0);
    do_req(1, 0, 0);
    check_follow(1);
    do_req(5, 0, 0);
    check_follow(1);
    do_req(3, 1, 0);
    check_follow(3);

    for (int i = 0; i < 16; i++) begin
      s = int'($urandom_range(7, 0));
      do_req(s, bit'($urandom_range(1, 0)), 0);
      check_follow(model_cur);
    end

    do_req(0, 0, 0);
    @(negedge clk1);
    sel     = SW'(2);
    sel_req = 1'b1;
    @(negedge clk1);
    sel_req = 1'b0;
    repeat (6) @(negedge clk1);
    rstn = 1'b0;
    #1;
    chk("abort_clkout", longint'(clk_out), 0);
    chk("abort_busy", longint'(busy), 1);
    chk("abort_cur", longint'(cur_sel), 0);
    model_cur = 0;
    repeat (2) @(negedge clk1);
    rstn = 1'b1;
    @(negedge clk1);
    wait_idle("reboot", 200);
    chk("reboot_cur", longint'(cur_sel), 0);
    check_follow(0);

`ifdef GFMUX_TIMEOUT_EN
    stop3 = 1'b1;
    repeat (3) @(negedge clk1);
    do_req(3, 0, 1);
    repeat (10) @(negedge clk1);
    check_follow(model_cur);
    stop3 = 1'b0;
`endif

    repeat (4) @(negedge clk1);
    chk("queue_empty", longint'(q.size()), 0);
    chk("min_pulse_ok", longint'(min_w >= 5), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
